// File: rtl/multicycle_ctrl_pkg.sv
// Shared codes for the multi-cycle main controller: opcodes, ALUOp values,
// FSM state encodings and datapath mux select codes.
package ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_R_TYPE = 3'b010;
    localparam logic [2:0] ALUOP_ADDI   = 3'b100;
    localparam logic [2:0] ALUOP_SLTI   = 3'b101;
    localparam logic [2:0] ALUOP_LUI    = 3'b110;
    localparam logic [2:0] ALUOP_ORI    = 3'b111;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_MEM_ADDR = 4'd3;
    localparam logic [3:0] ST_MEM_RD   = 4'd4;
    localparam logic [3:0] ST_MEM_WB   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_R_EXEC   = 4'd7;
    localparam logic [3:0] ST_R_WB     = 4'd8;
    localparam logic [3:0] ST_I_EXEC   = 4'd9;
    localparam logic [3:0] ST_I_WB     = 4'd10;
    localparam logic [3:0] ST_BRANCH   = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] ASB_RT      = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    function automatic logic [2:0] itype_aluop(input logic [5:0] op);
        logic [2:0] aop;
        case (op)
            OP_SLTI: aop = ALUOP_SLTI;
            OP_ORI:  aop = ALUOP_ORI;
            OP_LUI:  aop = ALUOP_LUI;
            default: aop = ALUOP_ADDI;
        endcase
        return aop;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait.sv
// Wait-state counter for the memory handshake states; flags a timeout on the
// last permitted wait cycle so the controller can abort back to FETCH.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic hold,
    output logic timeout
);

    // Count is 0 in the first cycle of a wait state, so the limit is
    // MEM_TIMEOUT-1: the abort fires on the MEM_TIMEOUT-th unready cycle.
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_cnt <= 8'd0;
        else if (clear)
            r_cnt <= 8'd0;
        else if (hold)
            r_cnt <= r_cnt + 8'd1;
    end

    assign timeout = hold && (r_cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables plus ALUOp for the ALU controller.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic [1:0] pc_source_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       illegal_o,
    output logic       bus_err_o
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [5:0] r_opcode;
    logic       w_wait_st;
    logic       w_next_wait;
    logic       w_hold;
    logic       w_clear;
    logic       w_timeout;
    logic       w_illegal;

    assign w_wait_st   = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
    assign w_next_wait = (w_next == ST_FETCH) || (w_next == ST_MEM_RD) || (w_next == ST_MEM_WR);
    assign w_hold      = w_wait_st && !mem_ready_i;
    // A timeout that lands back in FETCH is a fresh entry and restarts the count.
    assign w_clear     = w_next_wait && ((w_next != r_state) || w_timeout);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (w_clear),
        .hold    (w_hold),
        .timeout (w_timeout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_opcode <= 6'd0;
        else if (r_state == ST_DECODE)
            r_opcode <= opcode_i;
    end

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            ST_IDLE:     w_next = ST_FETCH;
            ST_FETCH:    w_next = mem_ready_i ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW:                      w_next = ST_MEM_ADDR;
                    OP_R:                              w_next = ST_R_EXEC;
                    OP_ADDI, OP_SLTI, OP_ORI, OP_LUI:  w_next = ST_I_EXEC;
                    OP_BEQ, OP_BNE:                    w_next = ST_BRANCH;
                    OP_J, OP_JAL:                      w_next = ST_JUMP;
                    default: begin
                        w_next    = ST_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: w_next = (r_opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready_i)    w_next = ST_MEM_WB;
                else if (w_timeout) w_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                if (mem_ready_i || w_timeout) w_next = ST_FETCH;
            end
            ST_R_EXEC:   w_next = ST_R_WB;
            ST_I_EXEC:   w_next = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: w_next = ST_FETCH;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        pc_source_o     = PCSRC_ALU;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = RDST_RT;
        mem_to_reg_o    = M2R_ALUOUT;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = ASB_RT;
        alu_op_o        = 3'b000;
        case (r_state)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = ASB_FOUR;
                alu_op_o    = ALUOP_ADDI;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            ST_DECODE: begin
                alu_src_b_o = ASB_IMM_SH2;
                alu_op_o    = ALUOP_ADDI;
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ASB_IMM;
                alu_op_o    = ALUOP_ADDI;
            end
            ST_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = M2R_MDR;
            end
            ST_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_R_TYPE;
            end
            ST_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = RDST_RD;
            end
            ST_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ASB_IMM;
                alu_op_o    = itype_aluop(r_opcode);
            end
            ST_I_WB:     reg_write_o = 1'b1;
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_BRANCH;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
                branch_ne_o     = r_opcode[0];
            end
            ST_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PCSRC_JUMP;
                if (r_opcode == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = RDST_RA;
                    mem_to_reg_o = M2R_PC;
                end
            end
            default: ;
        endcase
    end

    assign illegal_o = w_illegal;
    assign bus_err_o = w_timeout;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle main control unit. Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables and the 3-bit ALUOp consumed by the ALU controller (the ALU controller uses ALUOp plus funct to select the ALU operation).
- Sits between instruction register opcode and datapath; stalls on a memory ready handshake; flags illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready_i in any memory state before aborting (1..255)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- opcode_i  in  6  instr[31:26] from instruction register, valid from DECODE onward
- mem_ready_i  in  1  memory completes access this cycle
- pc_write_o  out  1  unconditional PC write
- pc_write_cond_o  out  1  conditional PC write (branch)
- branch_ne_o  out  1  1 = BNE sense, 0 = BEQ sense
- pc_source_o  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- iord_o  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  load instruction register
- reg_write_o  out  1  register file write
- reg_dst_o  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg_o  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a_o  out  1  0 PC, 1 rs
- alu_src_b_o  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op_o  out  3  ALUOp to ALU controller
- illegal_o  out  1  one-cycle pulse on undefined opcode
- bus_err_o  out  1  one-cycle pulse on memory timeout

Behaviour:
- Shared package codes. ALUOp: R_TYPE 010, BRANCH 001, ADDI 100, SLTI 101, LUI 110, ORI 111. Opcodes: R 000000, BEQ 000100, BNE 000101, ADDI 001000, SLTI 001010, ORI 001101, LUI 001111, LW 100011, SW 101011, J 000010, JAL 000011.
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Moore outputs: decoded from the state register only. Every output not listed for a state is 0.
- Reset: rst_i asserted forces IDLE immediately, mid-instruction included. Wait counter clears. All outputs are 0 while in IDLE. IDLE always moves to FETCH on the next edge.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=100. Stays in FETCH while mem_ready_i=0. When mem_ready_i=1 in the same cycle: ir_write=1, pc_write=1, pc_source=00, next state DECODE. ir_write and pc_write are the only outputs gated by mem_ready_i.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=100 (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - R -> R_EXEC
  - ADDI/SLTI/ORI/LUI -> I_EXEC
  - BEQ/BNE -> BRANCH
  - J/JAL -> JUMP
  - any other opcode -> FETCH, with illegal_o=1 during this DECODE cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100. LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: mem_read=1, iord=1, waits on mem_ready_i, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, then FETCH.
- MEM_WR: mem_write=1, iord=1, waits on mem_ready_i, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010, then R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op from the opcode latched at DECODE (ADDI 100, SLTI 101, ORI 111, LUI 110), then I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, branch_ne = latched opcode[0], then FETCH.
- JUMP: pc_write=1, pc_source=10. For JAL also reg_write=1, reg_dst=10, mem_to_reg=10. Then FETCH.
- Opcode latch: opcode_i is captured in DECODE into an internal register used by all later states, so IR changes do not corrupt sequencing.
- Wait counter:
  - 8-bit; clears on entry to FETCH, MEM_RD or MEM_WR; increments each cycle that state is held with mem_ready_i=0.
  - If the counter reaches MEM_TIMEOUT with mem_ready_i still 0: bus_err_o=1 for that cycle, next state FETCH, PC unchanged.
  - If mem_ready_i=1 in that same cycle, ready wins: normal transition, no error.
- CPI: R/I/branch/jump 3–4 cycles; LW 5 and SW 4 with zero wait states.

Decomposition:
- Package ctrl_pkg: opcode constants, ALUOp constants, state enum, pc_source/reg_dst/mem_to_reg/alu_src_b codes. The ALU controller imports the same ALUOp constants.
- One sub-module, mem_wait_timer: counter plus timeout compare, with ports clk_i, rst_i, clear, hold, timeout.

Test Plan:
- Reset then ADD (opcode 000000), mem_ready=1 always -> IDLE, FETCH, DECODE, R_EXEC (alu_op=010), R_WB (reg_write=1, reg_dst=01). All outputs 0 during reset.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_read/iord held 4 cycles, then MEM_WB with mem_to_reg=01. Total 8 cycles.
- BNE (000101) -> BRANCH with alu_op=001, pc_write_cond=1, branch_ne=1. BEQ gives branch_ne=0.
- ORI, SLTI, LUI, ADDI -> I_EXEC alu_op = 111, 101, 110, 100 respectively.
- Opcode 111111 -> illegal_o pulses 1 cycle in DECODE, next FETCH. JAL -> reg_dst=10, mem_to_reg=10, pc_write=1.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> bus_err_o pulses at cycle 15, back to FETCH. rst_i asserted mid MEM_WR -> mem_write drops asynchronously, state IDLE.
